// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte sources / UART transmitter and the arbiter.
//
// Handshake: a requester byte moves when req_valid[i] and req_ready[i] are
// both high on a rising clk edge. A requester holds req_data/req_last stable
// while valid and not yet accepted. The transmitter side is a level strobe
// (uart_data_fin) answered by a rising edge on uart_transfer_fin.
//
// master : the environment (requesters plus transmitter) driving the arbiter
// slave  : the arbiter itself
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [7:0]         uart_data;
   logic               uart_data_fin;
   logic               uart_transfer_fin;
   logic               busy;
   logic [ID_W-1:0]    grant_id;
   logic               err_timeout;

   modport master (
      output req_valid, req_data, req_last, uart_transfer_fin,
      input  req_ready, uart_data, uart_data_fin, busy, grant_id, err_timeout
   );

   modport slave (
      input  req_valid, req_data, req_last, uart_transfer_fin,
      output req_ready, uart_data, uart_data_fin, busy, grant_id, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ byte
// sources. The UART stays locked to one requester for a whole packet; each
// byte is strobed with a FIN_HOLD-cycle level on uart_data_fin and completed
// by a synchronised rising edge on uart_transfer_fin. A watchdog abandons a
// transfer that never completes.
module uart_tx_arbiter #(
   parameter int N_REQ    = 4,
   parameter int ID_W     = 2,
   parameter int FIN_HOLD = 4,
   parameter int TIMEOUT  = 4096
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus,
   output logic [1:0]       dbg_state
);

   // Requester vectors are padded to a power of two so an ID_W-bit grant
   // always indexes inside the vector.
   localparam int N_PAD = 1 << ID_W;
   localparam int FC_W  = $clog2(FIN_HOLD);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD      = 2'd1,
      S_FIN_HI    = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [7:0]          data_q, data_d;
   logic                last_q, last_d;
   logic [FC_W-1:0]     fin_cnt_q, fin_cnt_d;
   logic [15:0]         wd_cnt_q, wd_cnt_d;
   logic [2:0]          sync_q, sync_d;

   logic [N_PAD-1:0]    valid_pad;
   logic [N_PAD-1:0]    last_pad;
   logic [8*N_PAD-1:0]  data_pad;
   logic [N_PAD-1:0]    ready_pad;
   logic [ID_W-1:0]     pick_id;
   logic                pick_hit;
   logic [ID_W:0]       cand_sum;
   logic                done_edge;
   logic                timeout_fire;

   // Widen the requester inputs to the padded width.
   always_comb begin
      valid_pad                 = '0;
      last_pad                  = '0;
      data_pad                  = '0;
      valid_pad[N_REQ-1:0]      = bus.req_valid;
      last_pad[N_REQ-1:0]       = bus.req_last;
      data_pad[8*N_REQ-1:0]     = bus.req_data;
   end

   // Round-robin search: first valid requester starting at rr_ptr+1 with wrap.
   // Walking the offsets from far to near lets the nearest hit win.
   always_comb begin
      pick_id  = '0;
      pick_hit = 1'b0;
      cand_sum = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
         if (cand_sum >= (ID_W+1)'(N_REQ)) begin
            cand_sum = cand_sum - (ID_W+1)'(N_REQ);
         end
         if (valid_pad[cand_sum[ID_W-1:0]]) begin
            pick_id  = cand_sum[ID_W-1:0];
            pick_hit = 1'b1;
         end
      end
   end

   // Two-flop synchroniser for transfer_fin plus one history flop for the edge.
   always_comb begin
      sync_d    = {sync_q[1:0], bus.uart_transfer_fin};
      done_edge = sync_q[1] & ~sync_q[2];
   end

   // Next-state and datapath updates for the packet scheduler.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      data_d       = data_q;
      last_d       = last_q;
      fin_cnt_d    = fin_cnt_q;
      wd_cnt_d     = wd_cnt_q;
      timeout_fire = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_hit) begin
               grant_d = pick_id;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // Lock is held while the granted source has no byte; no watchdog here.
            if (valid_pad[grant_q]) begin
               data_d    = data_pad[{grant_q, 3'b000} +: 8];
               last_d    = last_pad[grant_q];
               wd_cnt_d  = '0;
               fin_cnt_d = '0;
               state_d   = S_FIN_HI;
            end
         end
         S_FIN_HI: begin
            if (fin_cnt_q == FC_W'(FIN_HOLD-1)) begin
               state_d = S_WAIT_DONE;
            end else begin
               fin_cnt_d = fin_cnt_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            // A done edge on the expiry cycle takes priority over the abort.
            if (done_edge) begin
               if (last_q) begin
                  rr_ptr_d = grant_q;
                  state_d  = S_IDLE;
               end else begin
                  state_d = S_LOAD;
               end
            end else if (wd_cnt_q == 16'(TIMEOUT-1)) begin
               timeout_fire = 1'b1;
               rr_ptr_d     = grant_q;
               state_d      = S_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Only the locked requester sees ready, and only while a byte is awaited.
   always_comb begin
      ready_pad = '0;
      if (state_q == S_LOAD) begin
         ready_pad[grant_q] = 1'b1;
      end
   end

   // State register; reset drops the strobe asynchronously through state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant, pointer, byte latch, counters and synchroniser registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q   <= '0;
         rr_ptr_q  <= ID_W'(N_REQ-1);
         data_q    <= 8'h00;
         last_q    <= 1'b0;
         fin_cnt_q <= '0;
         wd_cnt_q  <= '0;
         sync_q    <= '0;
      end else begin
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         data_q    <= data_d;
         last_q    <= last_d;
         fin_cnt_q <= fin_cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         sync_q    <= sync_d;
      end
   end

   assign bus.req_ready     = ready_pad[N_REQ-1:0];
   assign bus.uart_data     = data_q;
   assign bus.uart_data_fin = (state_q == S_FIN_HI);
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.grant_id      = grant_q;
   assign bus.err_timeout   = timeout_fire;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a UART responder, a
// transaction-level scheduling model feeding an expected queue, and a
// per-cycle compare process, plus literal checks for latency and timing.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int N_REQ    = 4;
   localparam int ID_W     = 2;
   localparam int FIN_HOLD = 4;
   localparam int TIMEOUT  = 64;
   localparam int RESP_DLY = 3;
   localparam int DEPTH    = 32;
   localparam int W        = ID_W + 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

   uart_tx_arbiter #(
      .N_REQ(N_REQ), .ID_W(ID_W), .FIN_HOLD(FIN_HOLD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int err_seen = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] log_q[$];

   logic [8:0] src_mem [N_REQ][DEPTH];
   int         src_head [N_REQ] = '{default: 0};
   int         src_tail [N_REQ] = '{default: 0};
   logic [8:0] mdl_mem [N_REQ][DEPTH];
   int         mdl_head [N_REQ] = '{default: 0};
   int         mdl_tail [N_REQ] = '{default: 0};
   int         m_ptr = N_REQ - 1;

   logic resp_auto = 1'b1;
   logic man_done  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_byte(input int r, input logic [7:0] b, input logic l);
      src_mem[r][src_tail[r]] = {l, b};
      src_tail[r]++;
      mdl_mem[r][mdl_tail[r]] = {l, b};
      mdl_tail[r]++;
   endtask

   // Requester side: present queue heads, pop on valid&ready seen before the edge.
   initial begin : req_driver
      logic [N_REQ-1:0]   acc;
      logic [N_REQ-1:0]   v, l;
      logic [8*N_REQ-1:0] d;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         v = '0; l = '0; d = '0;
         for (int i = 0; i < N_REQ; i++) begin
            if (acc[i] && !rst) src_head[i]++;
            if (src_head[i] < src_tail[i]) begin
               v[i]         = 1'b1;
               d[8*i +: 8]  = src_mem[i][src_head[i]][7:0];
               l[i]         = src_mem[i][src_head[i]][8];
            end
         end
         bus.req_valid = v;
         bus.req_data  = d;
         bus.req_last  = l;
      end
   end

   // Transmitter side: auto mode answers RESP_DLY cycles after the strobe falls.
   initial begin : uart_resp
      int   cnt;
      int   hold;
      logic fin_last;
      cnt = 0; hold = 0; fin_last = 1'b0;
      bus.uart_transfer_fin = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (resp_auto) begin
            if (fin_last && !bus.uart_data_fin) begin
               cnt = RESP_DLY;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) hold = 2;
            end
            if (hold > 0) begin
               bus.uart_transfer_fin = 1'b1;
               hold--;
            end else begin
               bus.uart_transfer_fin = 1'b0;
            end
         end else begin
            cnt = 0; hold = 0;
            bus.uart_transfer_fin = man_done;
         end
         fin_last = bus.uart_data_fin;
      end
   end

   // ---------------- model ----------------
   // Whole packets in round-robin order from the pointer; pointer follows the
   // last requester served.
   task automatic model_schedule();
      int         pick;
      int         r;
      logic [8:0] e;
      do begin
         pick = -1;
         for (int off = 1; off <= N_REQ; off++) begin
            r = (m_ptr + off) % N_REQ;
            if (pick < 0 && mdl_head[r] < mdl_tail[r]) pick = r;
         end
         if (pick >= 0) begin
            do begin
               e = mdl_mem[pick][mdl_head[pick]];
               mdl_head[pick]++;
               exp_q.push_back({ID_W'(pick), e[7:0]});
            end while (!e[8] && mdl_head[pick] < mdl_tail[pick]);
            m_ptr = pick;
         end
      end while (pick >= 0);
   endtask

   // ---------------- scoreboard / compare ----------------
   initial begin : compare
      logic             fin_prev;
      logic             err_prev;
      int               run;
      logic [7:0]       data_hold;
      logic [W-1:0]     got;
      logic [W-1:0]     exp;
      logic [N_REQ-1:0] allowed;
      fin_prev = 1'b0; err_prev = 1'b0; run = 0; data_hold = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            fin_prev = 1'b0; err_prev = 1'b0; run = 0;
         end else begin
            allowed = '0;
            if (bus.busy && !bus.uart_data_fin) allowed[bus.grant_id] = 1'b1;
            check("ready_scope", 32'(bus.req_ready & ~allowed), 32'd0);
            if (bus.uart_data_fin) check("fin_busy", 32'(bus.busy), 32'd1);
            if (bus.uart_data_fin && !fin_prev) begin
               got = {bus.grant_id, bus.uart_data};
               log_q.push_back(got);
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL byte_unexpected: got %0h, expected none (t=%0t)", got, $time);
               end else begin
                  exp = exp_q.pop_front();
                  check("byte", 32'(got), 32'(exp));
               end
               data_hold = bus.uart_data;
               run = 1;
            end else if (bus.uart_data_fin) begin
               run++;
               check("data_stable", 32'(bus.uart_data), 32'(data_hold));
            end
            if (!bus.uart_data_fin && fin_prev) check("fin_len", 32'(run), 32'(FIN_HOLD));
            if (bus.err_timeout) begin
               err_seen++;
               check("err_width", 32'(err_prev), 32'd0);
            end
            fin_prev = bus.uart_data_fin;
            err_prev = bus.err_timeout;
         end
      end
   end

   // ---------------- helper waits ----------------
   function automatic int pending();
      int p = 0;
      for (int i = 0; i < N_REQ; i++) p += src_tail[i] - src_head[i];
      return p;
   endfunction

   task automatic wait_idle(input string name);
      logic ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!bus.busy && pending() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_idle"}, 32'(ok), 32'd1);
      check({name, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_fin(input logic lvl, input string name);
      logic ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.uart_data_fin === lvl) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_fin_wait"}, 32'(ok), 32'd1);
   endtask

   // Called at the negedge of WAIT_DONE cycle 1; returns the cycle of the abort.
   task automatic measure_wait(output int n, output logic hit);
      n = 1; hit = 1'b0;
      while (n <= 3 * TIMEOUT) begin
         if (bus.err_timeout) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_log(input string name, input int idx, input logic [W-1:0] exp);
      check(name, (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hDEAD, 32'(exp));
   endtask

   // ---------------- tests ----------------
   initial begin : tests
      int   base;
      int   n;
      int   fins;
      int   errs;
      logic hit;

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_data", 32'(bus.uart_data), 32'd0);
      check("rst_fin", 32'(bus.uart_data_fin), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_grant", 32'(bus.grant_id), 32'd0);
      check("rst_err", 32'(bus.err_timeout), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // all four valid: grant order 0,1,2,3,0
      base = log_q.size();
      push_byte(0, 8'h10, 1'b1);
      push_byte(0, 8'h14, 1'b1);
      push_byte(1, 8'h11, 1'b1);
      push_byte(2, 8'h12, 1'b1);
      push_byte(3, 8'h13, 1'b1);
      model_schedule();
      wait_idle("t2");
      check("t2_count", 32'(log_q.size() - base), 32'd5);
      check_log("t2_b0", base + 0, 10'h010);
      check_log("t2_b1", base + 1, 10'h111);
      check_log("t2_b2", base + 2, 10'h212);
      check_log("t2_b3", base + 3, 10'h313);
      check_log("t2_b4", base + 4, 10'h014);

      // single byte on req1: latency and strobe width
      base = log_q.size();
      @(negedge clk);
      push_byte(1, 8'h55, 1'b1);
      model_schedule();
      @(posedge clk); #2;
      check("t1_ready_idle", 32'(bus.req_ready), 32'd0);
      check("t1_busy_idle", 32'(bus.busy), 32'd0);
      @(posedge clk); #2;
      check("t1_ready_load", 32'(bus.req_ready), 32'b0010);
      check("t1_busy_load", 32'(bus.busy), 32'd1);
      check("t1_grant", 32'(bus.grant_id), 32'd1);
      check("t1_fin_load", 32'(bus.uart_data_fin), 32'd0);
      @(posedge clk); #2;
      check("t1_fin_rise", 32'(bus.uart_data_fin), 32'd1);
      check("t1_ready_fin", 32'(bus.req_ready), 32'd0);
      check("t1_data", 32'(bus.uart_data), 32'h55);
      fins = 1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
         if (bus.uart_data_fin) fins++;
      end
      check("t1_fin_cycles", 32'(fins), 32'd4);
      wait_idle("t1");
      check("t1_grant_idle", 32'(bus.grant_id), 32'd1);
      check("t1_busy_end", 32'(bus.busy), 32'd0);
      check_log("t1_b0", base, 10'h155);

      // req0 three-byte packet stays locked while req2 waits
      base = log_q.size();
      push_byte(0, 8'hA1, 1'b0);
      push_byte(0, 8'hA2, 1'b0);
      push_byte(0, 8'hA3, 1'b1);
      model_schedule();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (log_q.size() > base) break;
      end
      push_byte(2, 8'hC2, 1'b1);
      model_schedule();
      wait_idle("t3");
      check_log("t3_b0", base + 0, 10'h0A1);
      check_log("t3_b1", base + 1, 10'h0A2);
      check_log("t3_b2", base + 2, 10'h0A3);
      check_log("t3_b3", base + 3, 10'h2C2);

      // watchdog: no done at all
      resp_auto = 1'b0;
      man_done  = 1'b0;
      errs = err_seen;
      push_byte(1, 8'h44, 1'b1);
      model_schedule();
      wait_fin(1'b1, "t4");
      wait_fin(1'b0, "t4");
      measure_wait(n, hit);
      check("t4_err_hit", 32'(hit), 32'd1);
      check("t4_err_cycle", 32'(n), 32'(TIMEOUT));
      @(negedge clk);
      check("t4_busy_after", 32'(bus.busy), 32'd0);
      check("t4_err_after", 32'(bus.err_timeout), 32'd0);
      check("t4_grant", 32'(bus.grant_id), 32'd1);
      check("t4_err_count", 32'(err_seen - errs), 32'd1);
      // next search starts after the aborted grant
      resp_auto = 1'b1;
      base = log_q.size();
      push_byte(1, 8'h45, 1'b1);
      push_byte(2, 8'h46, 1'b1);
      model_schedule();
      wait_idle("t4b");
      check_log("t4b_b0", base + 0, 10'h246);
      check_log("t4b_b1", base + 1, 10'h145);

      // done edge during the strobe is ignored
      resp_auto = 1'b0;
      man_done  = 1'b0;
      errs = err_seen;
      push_byte(3, 8'h33, 1'b1);
      model_schedule();
      wait_fin(1'b1, "t5");
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      wait_fin(1'b0, "t5");
      measure_wait(n, hit);
      check("t5_err_hit", 32'(hit), 32'd1);
      check("t5_err_cycle", 32'(n), 32'(TIMEOUT));
      @(negedge clk);
      check("t5_busy_after", 32'(bus.busy), 32'd0);
      // done edge on the expiry cycle wins
      errs = err_seen;
      push_byte(3, 8'h34, 1'b1);
      model_schedule();
      wait_fin(1'b1, "t5b");
      wait_fin(1'b0, "t5b");
      n = 1;
      while (n < TIMEOUT) begin
         if (n == TIMEOUT - 3) man_done = 1'b1;
         @(negedge clk);
         n++;
      end
      check("t5b_err_expiry", 32'(bus.err_timeout), 32'd0);
      check("t5b_busy_expiry", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("t5b_busy_after", 32'(bus.busy), 32'd0);
      check("t5b_err_count", 32'(err_seen - errs), 32'd0);
      man_done = 1'b0;
      resp_auto = 1'b1;
      repeat (4) @(negedge clk);

      // reset during the strobe of the second byte
      base = log_q.size();
      push_byte(1, 8'hB1, 1'b0);
      push_byte(1, 8'hB2, 1'b1);
      model_schedule();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (log_q.size() >= base + 2) break;
      end
      check("t6_fin_before", 32'(bus.uart_data_fin), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_fin_rst", 32'(bus.uart_data_fin), 32'd0);
      check("t6_ready_rst", 32'(bus.req_ready), 32'd0);
      check("t6_busy_rst", 32'(bus.busy), 32'd0);
      check("t6_grant_rst", 32'(bus.grant_id), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_ptr = N_REQ - 1;
      repeat (10) @(negedge clk);
      base = log_q.size();
      push_byte(0, 8'hD0, 1'b1);
      push_byte(1, 8'hD1, 1'b1);
      model_schedule();
      wait_idle("t6");
      check_log("t6_b0", base + 0, 10'h0D0);
      check_log("t6_b1", base + 1, 10'h1D1);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop so the run can never hang.
   initial begin : global_guard
      #500000;
      n_cmp++;
      n_bad++;
      $display("FAIL global_time_limit: got expired, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
